// File: rtl/snake_step_if.sv
// snake_pkg: shared heading type used by the steering logic and snake_step.
// snake_step_if: tick/steering inputs and head/tail/status outputs of snake_step.
//   master: drives clk_divided, dir, grow; observes the rest.
//   slave : snake_step itself.
package snake_pkg;
  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } direction;
endpackage

interface snake_step_if #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 64
);
  import snake_pkg::*;

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          clk_divided;
  direction      dir;
  logic          grow;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [XW-1:0] tail_x;
  logic [YW-1:0] tail_y;
  logic          tail_valid;
  logic [LW-1:0] length;
  logic          step_done;
  logic          dead;

  modport master (
    output clk_divided, dir, grow,
    input  head_x, head_y, tail_x, tail_y, tail_valid, length, step_done, dead
  );

  modport slave (
    input  clk_divided, dir, grow,
    output head_x, head_y, tail_x, tail_y, tail_valid, length, step_done, dead
  );
endinterface

// File: rtl/snake_step.sv
// snake_step: advances the snake head one cell per game tick (falling edge of
// clk_divided), keeps the body in a circular buffer, reports the vacated tail
// cell and scans the body for self-collision.
// Ports: clk, rst (sync, active high); bus (snake_step_if.slave):
//   in  clk_divided, dir, grow
//   out head_x, head_y, tail_x, tail_y, tail_valid, length, step_done, dead
module snake_step #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 12
) (
  input logic         clk,
  input logic         rst,
  snake_step_if.slave bus
);
  import snake_pkg::*;

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic          clk_div_prev;
  logic          tick;

  logic [XW-1:0] body_x [MAX_LEN];
  logic [YW-1:0] body_y [MAX_LEN];
  logic [PW-1:0] head_ptr, tail_ptr, scan_ptr;
  logic [PW-1:0] new_head_ptr, new_tail_ptr;
  logic [LW-1:0] len, new_len, scan_cnt;

  direction      last_dir, eff_dir;
  logic [XW-1:0] head_x_r, nx_x, tail_x_r;
  logic [YW-1:0] head_y_r, nx_y, tail_y_r;
  logic          grow_pending, do_grow;
  logic          dead_r, tail_valid_r, hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  // Datapath for the MOVE step and the per-entry scan compare.
  always_comb begin
    tick    = clk_div_prev & ~bus.clk_divided;
    eff_dir = (bus.dir == direction'(last_dir ^ 2'b10)) ? last_dir : bus.dir;
    nx_x    = head_x_r;
    nx_y    = head_y_r;
    case (eff_dir)
      UP:      nx_y = (head_y_r == '0) ? YW'(GRID_H - 1) : head_y_r - 1'b1;
      DOWN:    nx_y = (head_y_r == YW'(GRID_H - 1)) ? '0 : head_y_r + 1'b1;
      LEFT:    nx_x = (head_x_r == '0) ? XW'(GRID_W - 1) : head_x_r - 1'b1;
      default: nx_x = (head_x_r == XW'(GRID_W - 1)) ? '0 : head_x_r + 1'b1;
    endcase
    do_grow      = grow_pending && (len < LW'(MAX_LEN));
    new_len      = do_grow ? len + 1'b1 : len;
    new_head_ptr = ptr_inc(head_ptr);
    new_tail_ptr = do_grow ? tail_ptr : ptr_inc(tail_ptr);
    hit          = (body_x[scan_ptr] == head_x_r) && (body_y[scan_ptr] == head_y_r);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (tick && !dead_r) state_nx = S_MOVE;
      S_MOVE:  state_nx = S_SCAN;
      S_SCAN:  if (scan_cnt == LW'(1)) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      clk_div_prev <= 1'b0;
      last_dir     <= UP;
      grow_pending <= 1'b0;
      dead_r       <= 1'b0;
      tail_valid_r <= 1'b0;
      tail_x_r     <= '0;
      tail_y_r     <= '0;
      head_x_r     <= XW'(INIT_X);
      head_y_r     <= YW'(INIT_Y);
      head_ptr     <= PW'(INIT_LEN - 1);
      tail_ptr     <= '0;
      len          <= LW'(INIT_LEN);
      scan_ptr     <= '0;
      scan_cnt     <= '0;
      // Slot 0 holds the tail, slot INIT_LEN-1 the head.
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          body_x[i] <= XW'(INIT_X);
          body_y[i] <= YW'(INIT_Y + INIT_LEN - 1 - int'(i));
        end else begin
          body_x[i] <= '0;
          body_y[i] <= '0;
        end
      end
    end else begin
      state        <= state_nx;
      clk_div_prev <= bus.clk_divided;
      tail_valid_r <= 1'b0;
      // A grow arriving in the MOVE cycle itself is kept for the next step.
      if (bus.grow)
        grow_pending <= 1'b1;
      else if (state == S_MOVE)
        grow_pending <= 1'b0;

      case (state)
        S_MOVE: begin
          last_dir               <= eff_dir;
          head_x_r               <= nx_x;
          head_y_r               <= nx_y;
          head_ptr               <= new_head_ptr;
          body_x[new_head_ptr]   <= nx_x;
          body_y[new_head_ptr]   <= nx_y;
          len                    <= new_len;
          tail_ptr               <= new_tail_ptr;
          if (!do_grow) begin
            tail_valid_r <= 1'b1;
            tail_x_r     <= body_x[tail_ptr];
            tail_y_r     <= body_y[tail_ptr];
          end
          // Scan walks from the surviving tail up to the entry behind the head.
          scan_ptr <= new_tail_ptr;
          scan_cnt <= new_len - 1'b1;
        end
        S_SCAN: begin
          if (hit) dead_r <= 1'b1;
          scan_ptr <= ptr_inc(scan_ptr);
          scan_cnt <= scan_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.head_x     = head_x_r;
  assign bus.head_y     = head_y_r;
  assign bus.tail_x     = tail_x_r;
  assign bus.tail_y     = tail_y_r;
  assign bus.tail_valid = tail_valid_r;
  assign bus.length     = len;
  assign bus.step_done  = (state == S_DONE);
  assign bus.dead       = dead_r;
endmodule

// File: tb/tb_snake_step.sv
module tb_snake_step;
  import snake_pkg::*;

  localparam int GRID_W    = 32;
  localparam int GRID_H    = 24;
  localparam int MAX_LEN   = 64;
  localparam int INIT_LEN  = 3;
  localparam int INIT_X    = 16;
  localparam int INIT_Y    = 12;
  localparam int TICK_HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  snake_step_if #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN)) bus ();

  snake_step #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN),
    .INIT_X  (INIT_X),
    .INIT_Y  (INIT_Y)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: body as a list of cells, head first.
  int       bx[$];
  int       by[$];
  direction m_last;
  bit       m_gp;
  bit       m_dead;

  typedef struct {
    int hx;
    int hy;
    int len;
    int dead;
    int cyc;
  } step_exp_t;

  typedef struct {
    int tx;
    int ty;
    int cyc;
  } tail_exp_t;

  step_exp_t step_q[$];
  tail_exp_t tail_q[$];
  step_exp_t se;
  tail_exp_t te;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_opp(input direction a, input direction b);
    case (a)
      UP:      return b == DOWN;
      DOWN:    return b == UP;
      LEFT:    return b == RIGHT;
      default: return b == LEFT;
    endcase
  endfunction

  task automatic model_reset();
    bx.delete();
    by.delete();
    for (int k = 0; k < INIT_LEN; k++) begin
      bx.push_back(INIT_X);
      by.push_back(INIT_Y + k);
    end
    m_last = UP;
    m_gp   = 0;
    m_dead = 0;
    step_q.delete();
    tail_q.delete();
  endtask

  task automatic model_step(input direction d, input int t);
    direction e;
    int nx, ny;
    bit hitm;
    if (m_dead) return;
    e  = is_opp(d, m_last) ? m_last : d;
    nx = bx[0];
    ny = by[0];
    case (e)
      RIGHT:   nx = (nx + 1) % GRID_W;
      LEFT:    nx = (nx + GRID_W - 1) % GRID_W;
      UP:      ny = (ny + GRID_H - 1) % GRID_H;
      default: ny = (ny + 1) % GRID_H;
    endcase
    m_last = e;
    if (!(m_gp && bx.size() < MAX_LEN)) begin
      tail_q.push_back('{bx[$], by[$], t + 2});
      void'(bx.pop_back());
      void'(by.pop_back());
    end
    m_gp = 0;
    hitm = 0;
    foreach (bx[k]) if (bx[k] == nx && by[k] == ny) hitm = 1;
    bx.push_front(nx);
    by.push_front(ny);
    m_dead = hitm;
    step_q.push_back('{nx, ny, bx.size(), int'(hitm), t + 1 + bx.size()});
  endtask

  // Monitor: pops expectations whenever the DUT presents a tail erase or step completion.
  always @(negedge clk) begin
    if (bus.tail_valid === 1'b1) begin
      if (tail_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_tail_valid: got tail_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        te = tail_q.pop_front();
        check("tail_x", int'(bus.tail_x), te.tx);
        check("tail_y", int'(bus.tail_y), te.ty);
        check("tail_cycle", cyc, te.cyc);
      end
    end
    if (bus.step_done === 1'b1) begin
      if (step_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_step_done: got step_done=1 expected none (cycle %0d)", cyc);
      end else begin
        se = step_q.pop_front();
        check("head_x", int'(bus.head_x), se.hx);
        check("head_y", int'(bus.head_y), se.hy);
        check("length", int'(bus.length), se.len);
        check("dead", int'(bus.dead), se.dead);
        check("done_cycle", cyc, se.cyc);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_head_x"}, int'(bus.head_x), INIT_X);
    check({tag, "_head_y"}, int'(bus.head_y), INIT_Y);
    check({tag, "_length"}, int'(bus.length), INIT_LEN);
    check({tag, "_tail_valid"}, int'(bus.tail_valid), 0);
    check({tag, "_step_done"}, int'(bus.step_done), 0);
    check({tag, "_dead"}, int'(bus.dead), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.clk_divided = 1'b0;
    bus.grow        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    model_reset();
    rst = 1'b0;
  endtask

  task automatic do_step(input direction d, input bit g);
    @(negedge clk);
    if (g) begin
      bus.grow = 1'b1;
      m_gp     = 1;
      @(negedge clk);
      bus.grow = 1'b0;
    end
    bus.dir         = d;
    bus.clk_divided = 1'b1;
    repeat (TICK_HALF) @(negedge clk);
    bus.clk_divided = 1'b0;
    model_step(d, cyc);
    repeat (TICK_HALF) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    direction d;
    int t;
    bus.clk_divided = 1'b0;
    bus.grow        = 1'b0;
    bus.dir         = UP;

    // First step from reset, then a rejected reversal, then vertical wrap.
    do_reset();
    do_step(UP, 0);
    do_step(DOWN, 0);
    repeat (11) do_step(UP, 0);
    do_step(UP, 0);
    // Horizontal wrap 31 -> 0.
    repeat (16) do_step(RIGHT, 0);

    // Reset asserted while the collision scan is in progress.
    do_reset();
    @(negedge clk);
    bus.dir         = UP;
    bus.clk_divided = 1'b1;
    repeat (TICK_HALF) @(negedge clk);
    bus.clk_divided = 1'b0;
    t = cyc;
    model_step(UP, t);
    repeat (3) @(negedge clk);
    check("scan_state_cycle", cyc, t + 3);
    rst = 1'b1;
    step_q.delete();
    tail_q.delete();
    @(negedge clk);
    check_reset_vals("midscan_rst");
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    repeat (2 * TICK_HALF) @(negedge clk);

    // Serpentine growth up to and past the buffer limit.
    do_reset();
    repeat (31) do_step(RIGHT, 1);
    do_step(UP, 1);
    repeat (31) do_step(LEFT, 1);
    check("capped_length", int'(bus.length), MAX_LEN);

    // Tight loop at length 5 bites itself; later ticks are ignored.
    do_reset();
    do_step(UP, 1);
    do_step(UP, 1);
    do_step(RIGHT, 0);
    do_step(DOWN, 0);
    do_step(LEFT, 0);
    do_step(UP, 0);
    check("model_dead_after_loop", int'(m_dead), 1);
    repeat (3) do_step(RIGHT, 0);
    check("frozen_head_x", int'(bus.head_x), bx[0]);
    check("frozen_head_y", int'(bus.head_y), by[0]);
    check("frozen_dead", int'(bus.dead), 1);
    check("frozen_length", int'(bus.length), 5);

    // Random walk with random growth; restart whenever the snake dies.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      if (m_dead) do_reset();
      d = direction'($urandom_range(0, 3));
      do_step(d, $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 200 && (step_q.size() != 0 || tail_q.size() != 0); i++)
      @(negedge clk);
    check("step_q_drained", step_q.size(), 0);
    check("tail_q_drained", tail_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
